// File: rtl/spi_pkg.sv
// Shared definitions for the synchronous SPI slave: mode encodings,
// FSM state type and bit-counter sizing.
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  function automatic int spi_bitcnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin followed by a one-flop
// edge detector that reports rise/fall of the synchronised level.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // The chain keeps sampling through reset so the detector can be preloaded
  // with the live level; that is what suppresses a spurious edge on release.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[STAGES-2:0], d};
    prev_q <= sync_q[STAGES-1];
  end

  assign q    = sync_q[STAGES-1];
  assign rise = ~reset & q & ~prev_q;
  assign fall = ~reset & ~q & prev_q;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave oversampled on clk: any CPOL/CPHA, parametrised width and bit
// order, rx word pulses and a valid/ready tx holding register.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no frame; sclk edges ignored, miso held at 0
// ST_ACTIVE | ss asserted; sample edges shift rx, shift edges drive tx
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter bit               CPOL        = 1'b0,
  parameter bit               CPHA        = 1'b1,
  parameter bit               LSB_FIRST   = 1'b0,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] TX_IDLE     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ss,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic             frame_end,
  output logic             frame_abort
);

  localparam int               CNT_W          = spi_bitcnt_w(WIDTH);
  localparam logic [1:0]       MODE           = {CPOL, CPHA};
  localparam bit               SAMPLE_ON_LEAD = (MODE == SPI_MODE0) || (MODE == SPI_MODE2);
  localparam bit               SHIFT_ON_LEAD  = (MODE == SPI_MODE1) || (MODE == SPI_MODE3);
  localparam logic [CNT_W-1:0] LAST_BIT       = CNT_W'(WIDTH - 1);

  logic ss_q, ss_rise, ss_fall;
  logic sclk_q, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_q;

  sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
    .clk(clk), .reset(reset), .d(ss), .q(ss_q), .rise(ss_rise), .fall(ss_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .reset(reset), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  always_ff @(posedge clk) begin
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_q = mosi_sync[SYNC_STAGES-1];

  spi_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
  logic             hold_full_q, hold_full_d;
  logic             rx_valid_q, rx_valid_d, underrun_q, underrun_d;
  logic             frame_end_q, frame_end_d, frame_abort_q, frame_abort_d;
  logic             any_edge, lead_edge, trail_edge, sample_edge, shift_edge, tx_load;
  logic [WIDTH-1:0] rx_shifted, tx_advanced;

  assign any_edge    = sclk_rise | sclk_fall;
  assign lead_edge   = any_edge & (sclk_q != CPOL);
  assign trail_edge  = any_edge & (sclk_q == CPOL);
  assign sample_edge = SAMPLE_ON_LEAD ? lead_edge : trail_edge;
  assign shift_edge  = SHIFT_ON_LEAD ? lead_edge : trail_edge;
  assign rx_shifted  = LSB_FIRST ? {mosi_q, rx_sr_q[WIDTH-1:1]} : {rx_sr_q[WIDTH-2:0], mosi_q};
  assign tx_advanced = LSB_FIRST ? (tx_sr_q >> 1) : (tx_sr_q << 1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rx_sr_d       = rx_sr_q;
    tx_sr_d       = tx_sr_q;
    rx_data_d     = rx_data_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    rx_valid_d    = 1'b0;
    underrun_d    = 1'b0;
    frame_end_d   = 1'b0;
    frame_abort_d = 1'b0;
    tx_load       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_rise) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
          rx_sr_d = '0;
          tx_load = SAMPLE_ON_LEAD;
        end
      end
      ST_ACTIVE: begin
        // An sclk edge landing on the ss fall belongs to no word.
        if (ss_fall) begin
          state_d       = ST_IDLE;
          frame_end_d   = 1'b1;
          frame_abort_d = (cnt_q != '0);
          cnt_d         = '0;
        end else begin
          if (sample_edge) begin
            rx_sr_d = rx_shifted;
            if (cnt_q == LAST_BIT) begin
              cnt_d      = '0;
              rx_data_d  = rx_shifted;
              rx_valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          if (shift_edge) begin
            if (cnt_q == '0) tx_load = 1'b1;
            else             tx_sr_d = tx_advanced;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A load always takes the old word; a same-cycle capture refills it.
    if (tx_load) begin
      tx_sr_d     = hold_full_q ? hold_q : TX_IDLE;
      underrun_d  = ~hold_full_q;
      hold_full_d = 1'b0;
    end
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rx_sr_q       <= '0;
      tx_sr_q       <= '0;
      rx_data_q     <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      rx_valid_q    <= 1'b0;
      underrun_q    <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rx_sr_q       <= rx_sr_d;
      tx_sr_q       <= tx_sr_d;
      rx_data_q     <= rx_data_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      rx_valid_q    <= rx_valid_d;
      underrun_q    <= underrun_d;
      frame_end_q   <= frame_end_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign miso        = (state_q == ST_ACTIVE) & (LSB_FIRST ? tx_sr_q[0] : tx_sr_q[WIDTH-1]);
  assign miso_oe     = ss_q & (state_q == ST_ACTIVE);
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = ~hold_full_q;
  assign tx_underrun = underrun_q;
  assign frame_end   = frame_end_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: eight WIDTH=12 instances (every CPOL/CPHA and
// bit order) plus one default WIDTH=8 instance with TX_IDLE=0x5A.
module tb_spi_slave_sync;

  localparam int NK = 9;
  localparam int H  = 8;

  logic clk = 1'b0;
  logic reset;
  logic mosi;
  logic        ss_v [NK];
  logic        sclk_v [NK];
  logic [11:0] tx_data_v [NK];
  logic        tx_valid_v [NK];
  logic        miso_v [NK], miso_oe_v [NK], rx_valid_v [NK], tx_ready_v [NK];
  logic        under_v [NK], fe_v [NK], fa_v [NK];
  logic [11:0] rx_data_v [NK];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NK; k++) begin : g_dut
    localparam int W = (k == 8) ? 8 : 12;
    logic [W-1:0] rxd;
    spi_slave_sync #(
      .WIDTH(W),
      .CPOL(((k >> 2) & 1) == 1),
      .CPHA((k == 8) ? 1'b1 : (((k >> 1) & 1) == 1)),
      .LSB_FIRST((k & 1) == 1),
      .SYNC_STAGES(2),
      .TX_IDLE(W'((k == 8) ? 8'h5A : 8'h00))
    ) u_dut (
      .clk(clk), .reset(reset), .ss(ss_v[k]), .sclk(sclk_v[k]), .mosi(mosi),
      .miso(miso_v[k]), .miso_oe(miso_oe_v[k]), .rx_data(rxd), .rx_valid(rx_valid_v[k]),
      .tx_data(tx_data_v[k][W-1:0]), .tx_valid(tx_valid_v[k]), .tx_ready(tx_ready_v[k]),
      .tx_underrun(under_v[k]), .frame_end(fe_v[k]), .frame_abort(fa_v[k])
    );
    assign rx_data_v[k] = 12'(rxd);
  end

  function automatic bit k_cpol(input int k);  return (k < 8) ? k[2] : 1'b0; endfunction
  function automatic bit k_cpha(input int k);  return (k < 8) ? k[1] : 1'b1; endfunction
  function automatic bit k_lsb(input int k);   return (k < 8) ? k[0] : 1'b0; endfunction
  function automatic int k_w(input int k);     return (k < 8) ? 12 : 8;      endfunction

  int tests = 0;
  int fails = 0;
  int act_k = 8;
  logic [11:0] tx_q [$];
  logic [11:0] rx_q [$];
  int under_cnt [NK];
  int fe_cnt [NK];
  int ab_cnt [NK];
  int ab_alone = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offers queued words to the active instance's holding register.
  initial begin
    for (int k = 0; k < NK; k++) begin
      tx_valid_v[k] = 1'b0;
      tx_data_v[k]  = '0;
    end
    forever begin
      @(negedge clk);
      if (tx_valid_v[act_k]) begin
        tx_valid_v[act_k] = 1'b0;
      end else if (!reset && tx_ready_v[act_k] && tx_q.size() > 0) begin
        tx_data_v[act_k]  = tx_q.pop_front();
        tx_valid_v[act_k] = 1'b1;
      end
    end
  end

  initial begin
    for (int k = 0; k < NK; k++) begin
      under_cnt[k] = 0; fe_cnt[k] = 0; ab_cnt[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < NK; k++) begin
        if (rx_valid_v[k]) rx_q.push_back(rx_data_v[k]);
        if (under_v[k]) under_cnt[k]++;
        if (fe_v[k]) fe_cnt[k]++;
        if (fa_v[k]) begin
          ab_cnt[k]++;
          if (!fe_v[k]) ab_alone++;
        end
      end
    end
  end

  // Master side of one word (or its first nb bits); returns bits seen on miso.
  task automatic xfer(input int k, input int nb, input logic [11:0] word, output logic [11:0] got);
    int w;
    bit cpol, cpha, lsb;
    w = k_w(k); cpol = k_cpol(k); cpha = k_cpha(k); lsb = k_lsb(k);
    got = '0;
    for (int i = 0; i < nb; i++) begin
      int b;
      b = lsb ? i : w - 1 - i;
      if (!cpha) begin
        mosi = word[b];
        wait_clk(H);
        got[b] = miso_v[k];
        sclk_v[k] = ~cpol;
        wait_clk(H);
        sclk_v[k] = cpol;
      end else begin
        sclk_v[k] = ~cpol;
        mosi = word[b];
        wait_clk(H);
        got[b] = miso_v[k];
        sclk_v[k] = cpol;
        wait_clk(H);
      end
    end
  endtask

  task automatic run_frame(input int k, input int n, input int ntx,
                           input logic [11:0] mw [3], input logic [11:0] tw [3],
                           input logic [11:0] erx [3], input logic [11:0] emi [3],
                           input int exp_under);
    logic [11:0] got;
    int u0, cyc;
    rx_q.delete();
    u0 = under_cnt[k];
    act_k = k;
    for (int j = 0; j < ntx; j++) tx_q.push_back(tw[j]);
    // CPHA=0 loads once more on the final trailing edge; give it a word.
    if (!k_cpha(k) && ntx == n) tx_q.push_back(12'h000);
    if (ntx > 0) begin
      cyc = 0;
      while (tx_ready_v[k] && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      chk("tx_hold_filled", tx_ready_v[k], 0);
    end
    ss_v[k] = 1'b1;
    wait_clk(H);
    for (int j = 0; j < n; j++) begin
      xfer(k, k_w(k), mw[j], got);
      chk($sformatf("miso_word k%0d w%0d", k, j), got, emi[j]);
    end
    wait_clk(H);
    ss_v[k] = 1'b0;
    wait_clk(2 * H);
    chk($sformatf("rx_count k%0d", k), rx_q.size(), n);
    for (int j = 0; j < n; j++)
      if (j < rx_q.size()) chk($sformatf("rx_word k%0d w%0d", k, j), rx_q[j], erx[j]);
    chk($sformatf("underruns k%0d", k), under_cnt[k] - u0, exp_under);
    tx_q.delete();
  endtask

  task automatic chk_reset_outs(input int k);
    chk($sformatf("reset_outputs k%0d", k),
        {miso_v[k], miso_oe_v[k], rx_valid_v[k], under_v[k], fe_v[k], fa_v[k], tx_ready_v[k]},
        7'b0000001);
    chk($sformatf("reset_rx_data k%0d", k), rx_data_v[k], 0);
  endtask

  typedef struct {
    int          k;
    logic [11:0] mosi_w;
    logic [11:0] tx_w;
    logic [11:0] exp_rx;
    logic [11:0] exp_miso;
  } vec_t;

  vec_t tbl [24];

  initial begin
    logic [11:0] mw [3], tw [3], er [3], em [3];
    logic [11:0] words [3];
    logic [11:0] got, mask;
    int fe0, ab0, k, n;

    reset = 1'b1;
    mosi  = 1'b0;
    for (int i = 0; i < NK; i++) begin
      ss_v[i]   = 1'b0;
      sclk_v[i] = k_cpol(i);
    end
    wait_clk(10);
    for (int i = 0; i < NK; i++) chk_reset_outs(i);
    reset = 1'b0;
    wait_clk(5);

    // Mode 1 default: 0xA5 in, 0x3C out.
    mw = '{12'h0A5, 12'h0, 12'h0}; tw = '{12'h03C, 12'h0, 12'h0};
    run_frame(8, 1, 1, mw, tw, mw, tw, 0);
    chk("tx_ready_after_load", tx_ready_v[8], 1);

    words = '{12'h123, 12'hABC, 12'hFFF};
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 3; j++)
        tbl[i*3+j] = '{i, words[j], words[2-j], words[j], words[2-j]};
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 3; j++) begin
        mw[j] = tbl[i*3+j].mosi_w;   tw[j] = tbl[i*3+j].tx_w;
        er[j] = tbl[i*3+j].exp_rx;   em[j] = tbl[i*3+j].exp_miso;
      end
      run_frame(tbl[i*3].k, 3, 3, mw, tw, er, em, 0);
    end

    // Empty holding register: TX_IDLE goes out, one underrun.
    mw = '{12'h011, 12'h0, 12'h0}; em = '{12'h05A, 12'h0, 12'h0};
    run_frame(8, 1, 0, mw, tw, mw, em, 1);

    // ss dropped after 5 of 8 bits.
    act_k = 8; rx_q.delete();
    fe0 = fe_cnt[8]; ab0 = ab_cnt[8];
    ss_v[8] = 1'b1;
    wait_clk(H);
    xfer(8, 5, 12'h0C3, got);
    wait_clk(H);
    ss_v[8] = 1'b0;
    wait_clk(2 * H);
    chk("abort_frame_end", fe_cnt[8] - fe0, 1);
    chk("abort_frame_abort", ab_cnt[8] - ab0, 1);
    chk("abort_with_end", ab_alone, 0);
    chk("abort_no_rx", rx_q.size(), 0);
    mw = '{12'h081, 12'h0, 12'h0}; tw = '{12'h0E7, 12'h0, 12'h0};
    run_frame(8, 1, 1, mw, tw, mw, tw, 0);

    // Reset mid-word with ss held high.
    act_k = 8; rx_q.delete();
    ss_v[8] = 1'b1;
    wait_clk(H);
    xfer(8, 4, 12'h0F0, got);
    reset = 1'b1;
    wait_clk(2);
    chk_reset_outs(8);
    wait_clk(2);
    reset = 1'b0;
    fe0 = fe_cnt[8];
    xfer(8, 8, 12'h0FF, got);
    wait_clk(H);
    chk("post_reset_no_rx", rx_q.size(), 0);
    chk("post_reset_oe_low", miso_oe_v[8], 0);
    ss_v[8] = 1'b0;
    wait_clk(2 * H);
    chk("post_reset_no_frame_end", fe_cnt[8] - fe0, 0);
    mw = '{12'h05C, 12'h0, 12'h0}; tw = '{12'h096, 12'h0, 12'h0};
    run_frame(8, 1, 1, mw, tw, mw, tw, 0);

    // Random frames: every word sent must come back, every queued tx word goes out in order.
    for (int r = 0; r < 6; r++) begin
      k = $urandom_range(0, 8);
      n = $urandom_range(1, 3);
      mask = (k == 8) ? 12'h0FF : 12'hFFF;
      for (int j = 0; j < 3; j++) begin
        mw[j] = 12'($urandom) & mask;
        tw[j] = 12'($urandom) & mask;
      end
      run_frame(k, n, n, mw, tw, mw, tw, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

endmodule
